// File: rtl/cpu_arb_pkg.sv
// Shared types and widths for the IF/MEM shared-memory arbiter.
package cpu_arb_pkg;

  localparam int unsigned LAT_CNT_W = 4;
  localparam int unsigned STARVE_W  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {PORT_IF, PORT_DM} port_id_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter tracking the memory latency of the transaction in flight.
module mem_lat_timer
  import cpu_arb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  output logic                 done_o
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the last wait cycle: the count reaches zero at the coming edge.
  assign done_o = (cnt_q <= LAT_CNT_W'(1));

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-ported fixed-latency memory between IF and MEM, one access in flight.
// Define ARB_PERF_CNT_EN to add saturating stall and transaction counters.
module shared_mem_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall_o,
  output logic [31:0]       perf_dm_stall_o,
  output logic [31:0]       perf_xact_o
`endif
);

  arb_state_t          state_q, state_d;
  port_id_t            win_q, win_d, arb_win;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                we_q, we_d, if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_elig, dm_elig, starved, arb_go, lat_load, lat_done;

  // A port is not eligible in the cycle its own response is delivered.
  assign if_elig = if_req_i & ~if_valid_q;
  assign dm_elig = dm_req_i & ~dm_valid_q;
  assign starved = (starve_q == STARVE_W'(STARVE_MAX));
  assign arb_go  = (state_q == IDLE) & (if_elig | dm_elig);
  assign arb_win = (dm_elig & ~(if_elig & starved)) ? PORT_DM : PORT_IF;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_go) state_d = ISSUE;
      ISSUE:   state_d = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (lat_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o = (state_q == ISSUE);
    mem_we_o = mem_en_o & we_q;
    if_gnt_o = mem_en_o & (win_q == PORT_IF);
    dm_gnt_o = mem_en_o & (win_q == PORT_DM);
    lat_load = mem_en_o;
  end

  always_comb begin
    win_d    = win_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    starve_d = starve_q;
    if (arb_go) begin
      win_d   = arb_win;
      addr_d  = (arb_win == PORT_DM) ? dm_addr_i : if_addr_i;
      wdata_d = dm_wdata_i;
      we_d    = (arb_win == PORT_DM) & dm_we_i;
      if (arb_win == PORT_IF) begin
        starve_d = '0;
      end else if (if_elig && !starved) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
    if_valid_d = (state_q == RESP) & (win_q == PORT_IF);
    dm_valid_d = (state_q == RESP) & (win_q == PORT_DM);
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if ((state_q == RESP) && !we_q) begin
      if (win_q == PORT_IF) begin
        if_rdata_d = mem_rdata_i;
      end else begin
        dm_rdata_d = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_q      <= PORT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      starve_q   <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      starve_q   <= starve_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  mem_lat_timer u_lat_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (lat_load),
    .load_val_i (LAT_CNT_W'(MEM_LAT - 1)),
    .done_o     (lat_done)
  );

  assign if_valid_o  = if_valid_q;
  assign dm_valid_o  = dm_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_if_o  = if_req_i & ~if_valid_q;
  assign stall_mem_o = dm_req_i & ~dm_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d, perf_dm_q, perf_dm_d, perf_xact_q, perf_xact_d;

  always_comb begin
    perf_if_d   = perf_if_q;
    perf_dm_d   = perf_dm_q;
    perf_xact_d = perf_xact_q;
    if (stall_if_o && (perf_if_q != '1)) perf_if_d = perf_if_q + 32'd1;
    if (stall_mem_o && (perf_dm_q != '1)) perf_dm_d = perf_dm_q + 32'd1;
    if (mem_en_o && (perf_xact_q != '1)) perf_xact_d = perf_xact_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_if_q   <= '0;
      perf_dm_q   <= '0;
      perf_xact_q <= '0;
    end else begin
      perf_if_q   <= perf_if_d;
      perf_dm_q   <= perf_dm_d;
      perf_xact_q <= perf_xact_d;
    end
  end

  assign perf_if_stall_o = perf_if_q;
  assign perf_dm_stall_o = perf_dm_q;
  assign perf_xact_o     = perf_xact_q;
`endif

endmodule
